// File: rtl/if_id_queue.sv
// IF/ID pipeline buffer: DEPTH-entry in-order queue between fetch and decode,
// with hazard hold, branch flush, occupancy output and a saturating stall counter.
module if_id_queue #(
  parameter int                 FIELD_W    = 4,
  parameter int                 PC_W       = 16,
  parameter int                 DEPTH      = 2,
  parameter logic [FIELD_W-1:0] NOP_OPCODE = '0,
  localparam int                CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*FIELD_W-1:0] in_instr,
  input  logic [PC_W-1:0]      in_pc,
  input  logic                 hazard,
  input  logic                 flush,
  output logic                 out_valid,
  output logic [FIELD_W-1:0]   opcode_o,
  output logic [FIELD_W-1:0]   one_o,
  output logic [FIELD_W-1:0]   two_o,
  output logic [FIELD_W-1:0]   three_o,
  output logic [PC_W-1:0]      PC_o,
  output logic [CNT_W-1:0]     count,
  output logic [15:0]          stall_cnt
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int INSTR_W = 4 * FIELD_W;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [15:0]      stall_q, stall_d;
  logic             push, pop;
  entry_t           head;

  // Handshake; a full queue never accepts, even while the head is leaving.
  always_comb begin
    in_ready  = !reset && !flush && (count_q < CNT_W'(DEPTH));
    out_valid = (count_q != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && !hazard && !flush;
  end

  // NOTE: every signal assigned here gets a default first, so no latch is inferred.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    stall_d  = stall_q;

    if (out_valid && hazard && !flush && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by natural overflow.
      if (push) begin
        mem_d[wr_ptr_q] = '{instr: in_instr, pc: in_pc};
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
    end
  end

  // NOTE: storage is not reset; count_q gates every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    head      = mem_q[rd_ptr_q];
    opcode_o  = NOP_OPCODE;
    one_o     = '0;
    two_o     = '0;
    three_o   = '0;
    PC_o      = '0;
    if (out_valid) begin
      opcode_o = head.instr[4*FIELD_W-1 -: FIELD_W];
      one_o    = head.instr[3*FIELD_W-1 -: FIELD_W];
      two_o    = head.instr[2*FIELD_W-1 -: FIELD_W];
      three_o  = head.instr[FIELD_W-1:0];
      PC_o     = head.pc;
    end
    count     = count_q;
    stall_cnt = stall_q;
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_if_id_queue;

  localparam int             FW    = 4;
  localparam int             PW    = 16;
  localparam int             DEPTH = 2;
  localparam int             CW    = $clog2(DEPTH + 1);
  localparam int             IW    = 4 * FW;
  localparam logic [FW-1:0]  NOP   = 4'h0;

  logic          clk = 1'b0;
  logic          reset, in_valid, hazard, flush;
  logic [IW-1:0] in_instr;
  logic [PW-1:0] in_pc;
  logic          in_ready, out_valid;
  logic [FW-1:0] opcode_o, one_o, two_o, three_o;
  logic [PW-1:0] PC_o;
  logic [CW-1:0] count;
  logic [15:0]   stall_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: entries in arrival order plus the stall counter.
  logic [IW-1:0] m_instr [$];
  logic [PW-1:0] m_pc    [$];
  logic [15:0]   m_stall = 16'd0;

  if_id_queue #(.FIELD_W(FW), .PC_W(PW), .DEPTH(DEPTH), .NOP_OPCODE(NOP)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .hazard(hazard), .flush(flush),
    .out_valid(out_valid), .opcode_o(opcode_o), .one_o(one_o), .two_o(two_o),
    .three_o(three_o), .PC_o(PC_o), .count(count), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // Advance the model by one edge using the inputs currently driven, then clock the DUT.
  task automatic tick();
    bit do_pop, do_push;
    if (reset) begin
      m_instr.delete(); m_pc.delete(); m_stall = 16'd0;
    end else if (flush) begin
      m_instr.delete(); m_pc.delete();
    end else begin
      do_pop  = (m_pc.size() != 0) && !hazard;
      do_push = in_valid && (m_pc.size() < DEPTH);
      if ((m_pc.size() != 0) && hazard && (m_stall != 16'hFFFF)) m_stall = m_stall + 16'd1;
      if (do_pop) begin void'(m_instr.pop_front()); void'(m_pc.pop_front()); end
      if (do_push) begin m_instr.push_back(in_instr); m_pc.push_back(in_pc); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; in_valid = 1'b0; hazard = 1'b0; flush = 1'b0;
    in_instr = '0; in_pc = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b required 0", in_ready); end
    tick(); tick();
    reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b required 0", out_valid); end
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count got %0d required 0", count); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall got %0d required 0", stall_cnt); end
    checks++; if ({opcode_o, one_o, two_o, three_o, PC_o} !== {NOP, 12'h000, 16'h0000}) begin
      errors++; $display("FAIL reset_fields got %0h/%0h/%0h/%0h pc %0d required NOP/0/0/0 pc 0",
                         opcode_o, one_o, two_o, three_o, PC_o);
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got %0b required 1", in_ready); end
  endtask

  task automatic test_single();
    idle_inputs();
    in_valid = 1'b1; in_instr = 16'h2345; in_pc = 16'd15;
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if ({out_valid, opcode_o, one_o, two_o, three_o, PC_o} !== {1'b1, 16'h2345, 16'd15}) begin
      errors++; $display("FAIL single_head got v%0b %0h%0h%0h%0h pc %0d required v1 2345 pc 15",
                         out_valid, opcode_o, one_o, two_o, three_o, PC_o);
    end
    tick();
    checks++; if (out_valid !== 1'b0 || opcode_o !== NOP) begin
      errors++; $display("FAIL single_popped got v%0b op %0h required v0 op %0h", out_valid, opcode_o, NOP);
    end
  endtask

  task automatic test_hazard();
    idle_inputs();
    hazard = 1'b1;
    in_valid = 1'b1; in_instr = 16'hABCD; in_pc = 16'd17;
    tick();
    in_instr = 16'h1111; in_pc = 16'd18;
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (count !== CW'(2) || in_ready !== 1'b0) begin
      errors++; $display("FAIL hazard_full got count %0d rdy %0b required count 2 rdy 0", count, in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      checks++; if (opcode_o !== 4'hA || PC_o !== 16'd17) begin
        errors++; $display("FAIL hazard_hold got op %0h pc %0d required op a pc 17", opcode_o, PC_o);
      end
      checks++; if (stall_cnt !== m_stall) begin
        errors++; $display("FAIL hazard_stall got %0d required %0d", stall_cnt, m_stall);
      end
      tick();
    end
    hazard = 1'b0;
    #1;
    checks++; if (PC_o !== 16'd17) begin errors++; $display("FAIL release_first got pc %0d required 17", PC_o); end
    tick();
    checks++; if (PC_o !== 16'd18) begin errors++; $display("FAIL release_second got pc %0d required 18", PC_o); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL release_empty got %0b required 0", out_valid); end
  endtask

  task automatic test_wrap();
    int pushed = 0;
    int popped = 0;
    int cyc = 0;
    idle_inputs();
    in_instr = 16'($urandom);
    while (popped < 10 && cyc < 200) begin
      hazard   = cyc[0];
      in_valid = (pushed < 10);
      in_pc    = 16'(100 + pushed);
      #1;
      checks++; if (in_ready !== (m_pc.size() < DEPTH)) begin
        errors++; $display("FAIL wrap_in_ready cycle %0d got %0b required %0b", cyc, in_ready, m_pc.size() < DEPTH);
      end
      if (m_pc.size() != 0 && !hazard) begin
        checks++; if (out_valid !== 1'b1 || PC_o !== 16'(100 + popped)) begin
          errors++; $display("FAIL wrap_order got v%0b pc %0d required v1 pc %0d", out_valid, PC_o, 100 + popped);
        end
        popped++;
      end
      if (in_valid && m_pc.size() < DEPTH) begin
        tick();
        pushed++;
        in_instr = 16'($urandom);
      end else begin
        tick();
      end
      cyc++;
    end
    checks++; if (popped != 10) begin errors++; $display("FAIL wrap_budget got %0d pops required 10", popped); end
  endtask

  task automatic test_flush();
    idle_inputs();
    hazard = 1'b1; in_valid = 1'b1;
    in_instr = 16'h3333; in_pc = 16'd30; tick();
    in_instr = 16'h4444; in_pc = 16'd31; tick();
    flush = 1'b1; in_instr = 16'h5555; in_pc = 16'd40;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %0b required 0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0; hazard = 1'b0;
    #1;
    checks++; if (count !== '0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_empty got count %0d v%0b required count 0 v0", count, out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b0 || PC_o === 16'd40) begin
        errors++; $display("FAIL flush_dropped got v%0b pc %0d required v0, pc 40 never shown", out_valid, PC_o);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    hazard = 1'b1; in_valid = 1'b1; in_instr = 16'h6789; in_pc = 16'd50;
    tick();
    hazard = 1'b0; in_instr = 16'h9876; in_pc = 16'd51;
    #1;
    checks++; if (count !== CW'(1) || PC_o !== 16'd50 || in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_before got count %0d pc %0d rdy %0b required 1/50/1", count, PC_o, in_ready);
    end
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (count !== CW'(1) || PC_o !== 16'd51 || opcode_o !== 4'h9) begin
      errors++; $display("FAIL b2b_after got count %0d pc %0d op %0h required 1/51/9", count, PC_o, opcode_o);
    end
    tick();
  endtask

  task automatic test_reset_full();
    idle_inputs();
    reset = 1'b1; tick(); reset = 1'b0;
    hazard = 1'b1; in_valid = 1'b1;
    in_instr = 16'h1234; in_pc = 16'd60; tick();
    in_instr = 16'h5678; in_pc = 16'd61; tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (stall_cnt !== 16'd5 || count !== CW'(2)) begin
      errors++; $display("FAIL prereset_state got stall %0d count %0d required 5/2", stall_cnt, count);
    end
    reset = 1'b1; tick(); reset = 1'b0; hazard = 1'b0;
    #1;
    checks++; if (count !== '0 || stall_cnt !== 16'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL midreset got count %0d stall %0d v%0b rdy %0b required 0/0/0/1",
                         count, stall_cnt, out_valid, in_ready);
    end
  endtask

  task automatic test_random();
    logic [IW-1:0] h;
    logic [70:0]   got, exp;
    bit            pending = 0;
    idle_inputs();
    for (int cyc = 0; cyc < 400; cyc++) begin
      reset  = ($urandom_range(0, 49) == 0);
      flush  = ($urandom_range(0, 19) == 0);
      hazard = ($urandom_range(0, 2) == 0);
      if (!pending) begin
        in_valid = ($urandom_range(0, 2) != 0);
        in_instr = 16'($urandom);
        in_pc    = 16'($urandom);
      end
      #1;
      h   = (m_instr.size() != 0) ? m_instr[0] : '0;
      exp = {!reset && !flush && (m_pc.size() < DEPTH), m_pc.size() != 0,
             (m_pc.size() != 0) ? h[IW-1 -: FW] : NOP, h[3*FW-1:0],
             (m_pc.size() != 0) ? m_pc[0] : 16'd0, CW'(m_pc.size()), m_stall};
      got = {in_ready, out_valid, opcode_o, one_o, two_o, three_o, PC_o, count, stall_cnt};
      checks++; if (got !== exp) begin
        errors++; $display("FAIL random cycle %0d got %h required %h", cyc, got, exp);
      end
      pending = in_valid && !(!reset && !flush && (m_pc.size() < DEPTH));
      tick();
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_hazard();
    test_wrap();
    test_flush();
    test_back_to_back();
    test_reset_full();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Parametrised IF/ID pipeline buffer between fetch and decode. It replaces the single-entry IF/ID register with a DEPTH-entry in-order queue and a valid/ready handshake on the fetch side. The queue supports a decode-side hazard stall, a branch flush, occupancy reporting and a saturating stall counter. Each queued instruction is split into opcode and three register/immediate fields, which are presented to decode with their PC.

## Interface
- FIELD_W, 4, width of each instruction field; instruction width is 4*FIELD_W
- PC_W, 16, program counter width
- DEPTH, 2, queue entries; power of two, ≥2
- NOP_OPCODE, 0, opcode driven when the queue is empty

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  queue accepts this cycle
- in_instr  in  4*FIELD_W  fetched instruction
- in_pc  in  PC_W  PC of in_instr
- hazard  in  1  decode stall; head entry is held
- flush  in  1  discard all queued entries (branch taken)
- out_valid  out  1  head entry valid
- opcode_o  out  FIELD_W  in_instr[4F-1:3F] of head entry
- one_o  out  FIELD_W  head entry [3F-1:2F]
- two_o  out  FIELD_W  head entry [2F-1:F]
- three_o  out  FIELD_W  head entry [F-1:0]
- PC_o  out  PC_W  head entry PC
- count  out  $clog2(DEPTH+1)  current occupancy
- stall_cnt  out  16  cycles with out_valid && hazard, saturating

## Operation
- Storage: circular buffer of DEPTH entries {instr, pc}, with wr_ptr and rd_ptr that wrap modulo DEPTH, plus a count register.
- Push: in_valid && in_ready at an edge writes mem[wr_ptr], and wr_ptr is incremented.
- Pop: out_valid && !hazard && !flush at an edge increments rd_ptr.
- A simultaneous push and pop leaves count unchanged. Push only increments count. Pop only decrements count.
- in_ready = !reset && !flush && (count < DEPTH). There is no same-cycle pass-through when full: a full queue with a pop in progress still deasserts in_ready.
- out_valid = (count != 0).
- Field outputs and PC_o are driven combinationally from mem[rd_ptr] when out_valid=1.
- When the queue is empty: opcode_o = NOP_OPCODE, one_o = two_o = three_o = 0, PC_o = 0.
- Flush: at the edge, count, wr_ptr and rd_ptr are set to 0. A push attempted that cycle is dropped (in_ready is already 0). Flush overrides hazard.
- stall_cnt increments on every edge where out_valid && hazard && !flush, and saturates at 16'hFFFF. Only reset clears it.
- Priority: reset > flush > push/pop.

## Timing
- Reset values: out_valid=0, count=0, stall_cnt=0, pointers=0, opcode_o=NOP_OPCODE, other fields and PC_o = 0.
- in_ready=0 during reset and rises in the first cycle after reset deasserts.
- Latency: an instruction accepted at edge N is visible on the outputs in the cycle after edge N, provided the queue was empty.
- hazard holds the head outputs stable for every cycle it is high. Pushes continue while count < DEPTH.
- Full (count=DEPTH): in_ready=0. Fetch must hold in_instr and in_pc until the handshake completes.
- Empty with hazard high: no pop, and stall_cnt does not increment.
- Wrap-around: pointer DEPTH-1 advances to 0, and ordering is preserved across the wrap.
- Reset or flush mid-stream: all entries are lost, and the next accepted instruction becomes the head one cycle later.

## Test plan
- Reset, then push instr 16'h2345 with PC 15 and hazard=0. Next cycle: opcode_o=2, one_o=3, two_o=4, three_o=5, PC_o=15, out_valid=1. The following cycle the entry has popped: out_valid=0, opcode_o=NOP_OPCODE.
- Hold hazard=1 and push 16'hABCD/PC 17, then 16'h1111/PC 18. Expect count=2, in_ready=0, outputs held at opcode 10, PC 17, and stall_cnt advancing 1 per cycle. Release hazard: PC_o shows 17, then 18, then out_valid=0.
- Run 10 pushes with alternating hazard through a DEPTH=2 queue. Every PC must emerge in order, exercising pointer wrap.
- Fill the queue, then assert flush together with in_valid=1 and new PC 40. Next cycle: count=0, out_valid=0, and PC 40 is never output.
- With count=1, push and pop at the same edge. count stays 1 and the new PC appears at the head.
- Assert reset for 1 cycle while full with stall_cnt=5. Next cycle: count=0, stall_cnt=0, out_valid=0, in_ready=1.
